// File: rtl/mp_link_ctrl.sv
// Two-player board link: filters the peer's asynchronous pause/reload/score lines,
// arbitrates the shared pause, sequences the match and stretches local reload pulses.

module mp_link_filt #(
  parameter int W             = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] filt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_reg;
  logic [W-1:0]  synced;
  logic [W-1:0]  last_reg;
  logic [W-1:0]  filt_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign filt   = filt_reg;

  // The whole word must hold still, so a bit-skewed transition never gets through.
  always_comb begin
    cnt_next = cnt_reg;
    if (synced != last_reg)
      cnt_next = '0;
    else if (cnt_reg != CNT_LAST)
      cnt_next = cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      last_reg <= '0;
      cnt_reg  <= '0;
      filt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      last_reg <= synced;
      cnt_reg  <= cnt_next;
      if (cnt_next == CNT_LAST)
        filt_reg <= synced;
    end
  end
endmodule

module mp_link_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int RESUME_DELAY  = 16,
  parameter int RELOAD_PULSE  = 8,
  parameter int WIN_SCORE     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       local_pause_req,
  input  logic       local_reload_req,
  input  logic [3:0] local_score,
  input  logic       player2_pause_raw,
  input  logic       player2_reload_raw,
  input  logic [3:0] player2_score_raw,
  output logic       player1_pause,
  output logic       player1_reload,
  output logic [3:0] player1_score,
  output logic       game_paused,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] peer_score,
  output logic       peer_reload_evt
);
  typedef enum logic [1:0] {ST_PAUSED, ST_PLAY, ST_OVER} state_t;

  localparam int RW = $clog2(RESUME_DELAY + 1);
  localparam int PW = $clog2(RELOAD_PULSE + 1);
  localparam logic [RW-1:0] RESUME_LAST = RW'(RESUME_DELAY - 1);
  localparam logic [PW-1:0] PULSE_LEN   = PW'(RELOAD_PULSE);
  localparam logic [3:0]    WIN         = 4'(WIN_SCORE);

  state_t        state_reg, state_next;
  logic [RW-1:0] resume_reg, resume_next;
  logic [1:0]    winner_reg, winner_next;
  logic [PW-1:0] pulse_reg;
  logic          pause_reg;
  logic [3:0]    score_reg;
  logic          reload_reg;
  logic          evt_reg;
  logic          peer_reload_d_reg;
  logic          peer_pause;
  logic          peer_reload;
  logic          pause_any;
  logic          local_win;
  logic          peer_win;
  logic          reload_accept;

  mp_link_filt #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_pause_filt (
    .clk(clk), .rst(rst), .raw(player2_pause_raw), .filt(peer_pause)
  );
  mp_link_filt #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_reload_filt (
    .clk(clk), .rst(rst), .raw(player2_reload_raw), .filt(peer_reload)
  );
  mp_link_filt #(.W(4), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_score_filt (
    .clk(clk), .rst(rst), .raw(player2_score_raw), .filt(peer_score)
  );

  assign pause_any     = pause_reg | peer_pause;
  assign local_win     = (local_score >= WIN);
  assign peer_win      = (peer_score >= WIN);
  assign reload_accept = (state_reg == ST_PLAY) && !reload_reg && local_reload_req;

  always_comb begin
    state_next  = state_reg;
    resume_next = resume_reg;
    winner_next = winner_reg;
    case (state_reg)
      ST_PAUSED: begin
        if (pause_any) begin
          resume_next = '0;
        end else if (resume_reg == RESUME_LAST) begin
          state_next  = ST_PLAY;
          resume_next = '0;
        end else begin
          resume_next = resume_reg + RW'(1);
        end
      end
      ST_PLAY: begin
        resume_next = '0;
        // A win outranks a simultaneous pause.
        if (local_win || peer_win) begin
          state_next  = ST_OVER;
          winner_next = {peer_win, local_win};
        end else if (pause_any) begin
          state_next = ST_PAUSED;
        end
      end
      ST_OVER: begin
        state_next = ST_OVER;
      end
      default: begin
        state_next = ST_PAUSED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_PAUSED;
      resume_reg <= '0;
      winner_reg <= 2'b00;
    end else begin
      state_reg  <= state_next;
      resume_reg <= resume_next;
      winner_reg <= winner_next;
    end
  end

  // Reload stretch keeps running after leaving PLAY; new requests are dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_reg <= 1'b0;
      pulse_reg  <= '0;
    end else if (reload_accept) begin
      reload_reg <= 1'b1;
      pulse_reg  <= PULSE_LEN;
    end else if (reload_reg) begin
      if (pulse_reg <= PW'(1)) begin
        reload_reg <= 1'b0;
        pulse_reg  <= '0;
      end else begin
        pulse_reg <= pulse_reg - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_reg         <= 1'b0;
      score_reg         <= 4'd0;
      evt_reg           <= 1'b0;
      peer_reload_d_reg <= 1'b0;
    end else begin
      pause_reg         <= local_pause_req;
      score_reg         <= local_score;
      evt_reg           <= peer_reload & ~peer_reload_d_reg & (state_reg == ST_PLAY);
      peer_reload_d_reg <= peer_reload;
    end
  end

  assign player1_pause   = pause_reg;
  assign player1_score   = score_reg;
  assign player1_reload  = reload_reg;
  assign peer_reload_evt = evt_reg;
  assign winner          = winner_reg;
  assign game_paused     = (state_reg != ST_PLAY);
  assign game_over       = (state_reg == ST_OVER);
endmodule

// File: tb/tb_mp_link_ctrl.sv
// Directed and randomized checks of mp_link_ctrl against timing rules and a windowed peer-score model.

module tb_mp_link_ctrl;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int RESUME = 16;
  localparam int PULSE  = 8;
  localparam int WIN    = 10;

  logic       clk;
  logic       rst;
  logic       local_pause_req;
  logic       local_reload_req;
  logic [3:0] local_score;
  logic       player2_pause_raw;
  logic       player2_reload_raw;
  logic [3:0] player2_score_raw;
  logic       player1_pause;
  logic       player1_reload;
  logic [3:0] player1_score;
  logic       game_paused;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] peer_score;
  logic       peer_reload_evt;

  int checks = 0;
  int errors = 0;

  logic [3:0] hist[$];
  logic [3:0] model_peer = 4'd0;
  logic [3:0] skew_seq [4];

  mp_link_ctrl #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RESUME_DELAY(RESUME),
    .RELOAD_PULSE(PULSE), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .rst(rst),
    .local_pause_req(local_pause_req), .local_reload_req(local_reload_req),
    .local_score(local_score),
    .player2_pause_raw(player2_pause_raw), .player2_reload_raw(player2_reload_raw),
    .player2_score_raw(player2_score_raw),
    .player1_pause(player1_pause), .player1_reload(player1_reload),
    .player1_score(player1_score),
    .game_paused(game_paused), .game_over(game_over), .winner(winner),
    .peer_score(peer_score), .peer_reload_evt(peer_reload_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Peer score is accepted once the raw word has been constant for STABLE edges,
  // seen SYNC edges late.
  task automatic tick();
    int n;
    int lo;
    bit same;
    @(posedge clk);
    hist.push_back(player2_score_raw);
    #1;
    n = hist.size();
    if (n >= SYNC + STABLE) begin
      lo = n - SYNC - STABLE;
      same = 1'b1;
      for (int i = lo + 1; i < lo + STABLE; i++)
        if (hist[i] !== hist[lo]) same = 1'b0;
      if (same) model_peer = hist[lo];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    local_pause_req = 1'b0; local_reload_req = 1'b0; local_score = 4'd0;
    player2_pause_raw = 1'b0; player2_reload_raw = 1'b0; player2_score_raw = 4'd0;
    tick(); tick();
    rst = 1'b0;
    hist.delete();
    model_peer = 4'd0;
  endtask

  task automatic wait_play(input int bound, output int n);
    n = 0;
    while (game_paused === 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int bad;
    int hold;
    logic [3:0] ls;
    logic lp;

    skew_seq[0] = 4'b1111; skew_seq[1] = 4'b1110; skew_seq[2] = 4'b1100; skew_seq[3] = 4'b1000;

    // T1 reset and initial resume
    do_reset();
    check("rst_game_paused", game_paused, 1);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_p1_reload", player1_reload, 0);
    check("rst_p1_pause", player1_pause, 0);
    check("rst_p1_score", player1_score, 0);
    check("rst_peer_score", peer_score, 0);
    check("rst_peer_evt", peer_reload_evt, 0);
    wait_play(100, n);
    check("t1_resume_cycles", n, RESUME);
    check("t1_winner", winner, 0);

    // T2 pause glitch filter and shared pause
    player2_pause_raw = 1'b1;
    repeat (3) tick();
    player2_pause_raw = 1'b0;
    bad = 0;
    repeat (15) begin tick(); if (game_paused !== 1'b0) bad++; end
    check("t2_glitch_ignored", bad, 0);
    player2_pause_raw = 1'b1;
    n = 0;
    while (game_paused === 1'b0 && n < 40) begin tick(); n++; end
    check("t2_pause_latency", n, SYNC + STABLE + 1);
    repeat (20 - n) tick();
    player2_pause_raw = 1'b0;
    wait_play(100, n);
    check("t2_resume_latency", n, SYNC + STABLE + RESUME);

    // T3 skewed score word
    player2_score_raw = 4'b0111;
    repeat (10) tick();
    check("t3_initial_score", peer_score, 7);
    bad = 0;
    for (int s = 0; s < 4; s++) begin
      player2_score_raw = skew_seq[s];
      repeat ((s == 3) ? 12 : 2) begin
        tick();
        if (!(peer_score === 4'd7 || peer_score === 4'd8)) bad++;
      end
    end
    check("t3_no_intermediate", bad, 0);
    check("t3_final_score", peer_score, 8);
    check("t3_model_score", peer_score, model_peer);
    check("t3_still_playing", game_over, 0);

    // T4 reload stretch, drop during pulse, drop in PAUSED
    check("t4_in_play", game_paused, 0);
    local_reload_req = 1'b1; tick(); local_reload_req = 1'b0;
    n = 0;
    while (player1_reload === 1'b1 && n < 30) begin
      n++;
      if (n == 3) local_reload_req = 1'b1;
      tick();
      local_reload_req = 1'b0;
    end
    check("t4_pulse_width", n, PULSE);
    cnt = 0;
    repeat (12) begin tick(); if (player1_reload === 1'b1) cnt++; end
    check("t4_second_dropped", cnt, 0);
    local_pause_req = 1'b1; tick(); tick();
    check("t4_local_pause_out", player1_pause, 1);
    check("t4_paused", game_paused, 1);
    local_reload_req = 1'b1; tick(); local_reload_req = 1'b0;
    cnt = 0;
    repeat (12) begin tick(); if (player1_reload === 1'b1) cnt++; end
    check("t4_paused_req_dropped", cnt, 0);

    // peer reload events only in PLAY, history tracked while paused
    player2_reload_raw = 1'b1;
    cnt = 0;
    repeat (12) begin tick(); if (peer_reload_evt === 1'b1) cnt++; end
    check("t4_evt_paused", cnt, 0);
    local_pause_req = 1'b0;
    wait_play(100, n);
    check("t4_back_to_play", game_paused, 0);
    cnt = 0;
    repeat (12) begin tick(); if (peer_reload_evt === 1'b1) cnt++; end
    check("t4_evt_stale_edge", cnt, 0);
    player2_reload_raw = 1'b0;
    repeat (10) tick();
    player2_reload_raw = 1'b1;
    cnt = 0;
    repeat (12) begin tick(); if (peer_reload_evt === 1'b1) cnt++; end
    check("t4_evt_in_play", cnt, 1);
    player2_reload_raw = 1'b0;
    repeat (10) tick();

    // T5 local win, then frozen
    local_score = 4'd10; tick();
    check("t5_over", game_over, 1);
    check("t5_winner_local", winner, 1);
    check("t5_over_paused", game_paused, 1);
    local_score = 4'd0; player2_score_raw = 4'd12;
    repeat (12) tick();
    check("t5_winner_frozen", winner, 1);
    check("t5_over_held", game_over, 1);
    check("t5_peer_score_tracks", peer_score, 12);
    local_reload_req = 1'b1; tick(); local_reload_req = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); if (player1_reload === 1'b1) cnt++; end
    check("t5_over_reload_dropped", cnt, 0);

    // tie
    do_reset();
    wait_play(100, n);
    check("t5_tie_play", game_paused, 0);
    player2_score_raw = 4'd10;
    repeat (SYNC + STABLE - 1) tick();
    check("t5_peer_not_yet", peer_score, 0);
    tick();
    check("t5_peer_accepted", peer_score, 10);
    check("t5_no_over_yet", game_over, 0);
    local_score = 4'd10; tick();
    check("t5_tie_over", game_over, 1);
    check("t5_tie_winner", winner, 3);

    // win and pause together
    do_reset();
    wait_play(100, n);
    local_pause_req = 1'b1; tick();
    check("t5_pause_out", player1_pause, 1);
    local_score = 4'd10; tick();
    check("t5_pause_win_over", game_over, 1);
    check("t5_pause_win_winner", winner, 1);

    // peer win
    do_reset();
    wait_play(100, n);
    player2_score_raw = 4'd11;
    n = 0;
    while (game_over === 1'b0 && n < 30) begin tick(); n++; end
    check("t5_peer_win_latency", n, SYNC + STABLE + 1);
    check("t5_peer_winner", winner, 2);

    // T6 asynchronous reset mid-pulse
    do_reset();
    wait_play(100, n);
    local_reload_req = 1'b1; tick(); local_reload_req = 1'b0;
    repeat (3) tick();
    check("t6_pulse_active", player1_reload, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_reload", player1_reload, 0);
    check("t6_async_paused", game_paused, 1);

    // randomized phase, held in PAUSED by the peer
    do_reset();
    player2_pause_raw = 1'b1;
    hold = 0;
    for (int k = 0; k < 300; k++) begin
      if (hold == 0) begin
        player2_score_raw = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      local_score        = 4'($urandom_range(0, 15));
      local_pause_req    = 1'($urandom_range(0, 1));
      local_reload_req   = 1'($urandom_range(0, 1));
      player2_reload_raw = 1'($urandom_range(0, 1));
      ls = local_score;
      lp = local_pause_req;
      tick();
      check("rnd_p1_score", player1_score, ls);
      check("rnd_p1_pause", player1_pause, lp);
      check("rnd_peer_score", peer_score, model_peer);
      check("rnd_paused", game_paused, 1);
      check("rnd_no_reload", player1_reload, 0);
      check("rnd_no_evt", peer_reload_evt, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
